// File: rtl/posit_extract_pipe.sv
// rtl/posit_extract_pipe.sv - two-stage posit field extractor (sign, scale, mantissa, zero/NaR)
module posit_extract_pipe #(
    parameter int N  = 32,
    parameter int es = 2,
    parameter int SW = $clog2(N) + es + 1,
    parameter int MW = N - es - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [SW-1:0] out_scale,
    output logic [MW-1:0] out_mant,
    output logic          out_zero,
    output logic          out_inf
);
    localparam int RW = $clog2(N);

    // Stage 1 state: regime polarity, bits below the first regime bit and the run length.
    // Only abs[N-4:0] is kept as body; abs[N-3] is always run or terminator and never reaches the output.
    logic           s1_valid_q, s1_valid_d;
    logic           s1_sign_q,  s1_sign_d;
    logic           s1_zero_q,  s1_zero_d;
    logic           s1_inf_q,   s1_inf_d;
    logic           s1_rbit_q,  s1_rbit_d;
    logic [N-4:0]   s1_body_q,  s1_body_d;
    logic [RW-1:0]  s1_run_q,   s1_run_d;

    // Stage 2 state drives the outputs directly.
    logic           s2_valid_q, s2_valid_d;
    logic           out_sign_q,  out_sign_d;
    logic [SW-1:0]  out_scale_q, out_scale_d;
    logic [MW-1:0]  out_mant_q,  out_mant_d;
    logic           out_zero_q,  out_zero_d;
    logic           out_inf_q,   out_inf_d;

    logic           adv;
    logic [N-2:0]   abs_c;
    logic [RW-1:0]  run_c;
    logic           run_on;
    logic [SW-1:0]  k_c;
    logic [N-4:0]   body_c;
    logic [es-1:0]  exp_c;
    logic [MW-2:0]  frac_c;
    logic [SW-1:0]  scale_c;

    // Both stages advance together whenever the output slot is free or being drained.
    assign adv       = out_ready | ~s2_valid_q;
    assign in_ready  = adv;
    assign out_valid = s2_valid_q;
    assign out_sign  = out_sign_q;
    assign out_scale = out_scale_q;
    assign out_mant  = out_mant_q;
    assign out_zero  = out_zero_q;
    assign out_inf   = out_inf_q;

    // Stage 1 decode: magnitude below the sign bit and length of the regime run.
    always_comb begin
        abs_c  = in_data[N-1] ? (~in_data[N-2:0] + (N-1)'(1)) : in_data[N-2:0];
        run_c  = '0;
        run_on = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (run_on && (abs_c[i] == abs_c[N-2])) begin
                run_c = run_c + RW'(1);
            end else begin
                run_on = 1'b0;
            end
        end
    end

    // Stage 2 decode: regime value, exponent and fraction after stripping sign, run and terminator.
    always_comb begin
        if (s1_rbit_q) begin
            k_c = SW'(s1_run_q) - SW'(1);
        end else begin
            k_c = SW'(0) - SW'(s1_run_q);
        end
        // A shift of run-1 on the body equals a shift of run+2 on the full word; a run
        // reaching bit 0 shifts everything out, giving a zero exponent and fraction.
        body_c  = s1_body_q << (s1_run_q - RW'(1));
        exp_c   = body_c[N-4 -: es];
        frac_c  = body_c[N-4-es:0];
        scale_c = (k_c << es) + SW'(exp_c);
    end

    // Next-state for both stages: load on advance, otherwise hold everything.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_zero_d   = s1_zero_q;
        s1_inf_d    = s1_inf_q;
        s1_rbit_d   = s1_rbit_q;
        s1_body_d   = s1_body_q;
        s1_run_d    = s1_run_q;
        s2_valid_d  = s2_valid_q;
        out_sign_d  = out_sign_q;
        out_scale_d = out_scale_q;
        out_mant_d  = out_mant_q;
        out_zero_d  = out_zero_q;
        out_inf_d   = out_inf_q;
        if (adv) begin
            s1_valid_d = in_valid;
            s1_sign_d  = in_data[N-1];
            s1_zero_d  = (in_data == '0);
            s1_inf_d   = (in_data == {1'b1, {(N-1){1'b0}}});
            s1_rbit_d  = abs_c[N-2];
            s1_body_d  = abs_c[N-4:0];
            s1_run_d   = run_c;
            s2_valid_d = s1_valid_q;
            out_zero_d = s1_zero_q;
            out_inf_d  = s1_inf_q;
            if (s1_zero_q || s1_inf_q) begin
                out_sign_d  = 1'b0;
                out_scale_d = '0;
                out_mant_d  = '0;
            end else begin
                out_sign_d  = s1_sign_q;
                out_scale_d = scale_c;
                out_mant_d  = {1'b1, frac_c};
            end
        end
    end

    // Pipeline registers with synchronous flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_rbit_q   <= 1'b0;
            s1_body_q   <= '0;
            s1_run_q    <= '0;
            s2_valid_q  <= 1'b0;
            out_sign_q  <= 1'b0;
            out_scale_q <= '0;
            out_mant_q  <= '0;
            out_zero_q  <= 1'b0;
            out_inf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_inf_q    <= s1_inf_d;
            s1_rbit_q   <= s1_rbit_d;
            s1_body_q   <= s1_body_d;
            s1_run_q    <= s1_run_d;
            s2_valid_q  <= s2_valid_d;
            out_sign_q  <= out_sign_d;
            out_scale_q <= out_scale_d;
            out_mant_q  <= out_mant_d;
            out_zero_q  <= out_zero_d;
            out_inf_q   <= out_inf_d;
        end
    end
endmodule

// File: tb/tb_posit_extract_pipe.sv
// tb/tb_posit_extract_pipe.sv - directed self-checking bench for posit_extract_pipe
module tb_posit_extract_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_scale;
    logic [27:0] out_mant;
    logic        out_zero;
    logic        out_inf;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] w   [8];
    logic        e_sg[8];
    logic [7:0]  e_sc[8];
    logic [27:0] e_mt[8];
    logic        e_z [8];
    logic        e_i [8];

    posit_extract_pipe #(.N(32), .es(2)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_scale(out_scale), .out_mant(out_mant),
        .out_zero(out_zero), .out_inf(out_inf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input string p, input int i);
        chk({p, "_sign"},  32'(out_sign),  32'(e_sg[i]));
        chk({p, "_scale"}, 32'(out_scale), 32'(e_sc[i]));
        chk({p, "_mant"},  32'(out_mant),  32'(e_mt[i]));
        chk({p, "_zero"},  32'(out_zero),  32'(e_z[i]));
        chk({p, "_inf"},   32'(out_inf),   32'(e_i[i]));
    endtask

    task automatic run_single(input int i);
        @(posedge clk); #1;
        out_ready = 1'b1; in_data = w[i]; in_valid = 1'b1;
        #1 chk($sformatf("single%0d_in_ready", i), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        #1 chk($sformatf("single%0d_lat1_valid", i), 32'(out_valid), 32'd0);
        @(posedge clk); #2;
        chk($sformatf("single%0d_lat2_valid", i), 32'(out_valid), 32'd1);
        chk_fields($sformatf("single%0d", i), i);
    endtask

    initial begin
        int sent, rcv, cyc;
        logic stalled_prev, in_fire;
        logic [31:0] sv_sign, sv_scale, sv_mant, sv_zero, sv_inf;

        w[0] = 32'h40000000; e_sg[0] = 0; e_sc[0] = 8'h00; e_mt[0] = 28'h8000000; e_z[0] = 0; e_i[0] = 0;
        w[1] = 32'hC0000000; e_sg[1] = 1; e_sc[1] = 8'h00; e_mt[1] = 28'h8000000; e_z[1] = 0; e_i[1] = 0;
        w[2] = 32'h66531748; e_sg[2] = 0; e_sc[2] = 8'h05; e_mt[2] = 28'hCA62E90; e_z[2] = 0; e_i[2] = 0;
        w[3] = 32'h7FFFFFFF; e_sg[3] = 0; e_sc[3] = 8'h78; e_mt[3] = 28'h8000000; e_z[3] = 0; e_i[3] = 0;
        w[4] = 32'h00000001; e_sg[4] = 0; e_sc[4] = 8'h88; e_mt[4] = 28'h8000000; e_z[4] = 0; e_i[4] = 0;
        w[5] = 32'h00000000; e_sg[5] = 0; e_sc[5] = 8'h00; e_mt[5] = 28'h0000000; e_z[5] = 1; e_i[5] = 0;
        w[6] = 32'h80000000; e_sg[6] = 0; e_sc[6] = 8'h00; e_mt[6] = 28'h0000000; e_z[6] = 0; e_i[6] = 1;
        w[7] = 32'h48000000; e_sg[7] = 0; e_sc[7] = 8'h01; e_mt[7] = 28'h8000000; e_z[7] = 0; e_i[7] = 0;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_scale",     32'(out_scale), 32'd0);
        chk("reset_mant",      32'(out_mant),  32'd0);
        chk("reset_flags",     32'({out_sign, out_zero, out_inf}), 32'd0);

        for (int i = 0; i < 8; i++) run_single(i);

        // Streaming with out_ready cycling 1,0,0,1.
        sent = 0; rcv = 0; cyc = 0; stalled_prev = 1'b0;
        sv_sign = 0; sv_scale = 0; sv_mant = 0; sv_zero = 0; sv_inf = 0;
        while (rcv < 8 && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            in_valid  = (sent < 8);
            in_data   = (sent < 8) ? w[sent] : 32'h0;
            #1;
            if (stalled_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_sign",  32'(out_sign),  sv_sign);
                chk("stall_scale", 32'(out_scale), sv_scale);
                chk("stall_mant",  32'(out_mant),  sv_mant);
                chk("stall_zero",  32'(out_zero),  sv_zero);
                chk("stall_inf",   32'(out_inf),   sv_inf);
            end
            chk("stream_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            in_fire = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk_fields($sformatf("stream%0d", rcv), rcv);
                rcv++;
            end
            stalled_prev = out_valid && !out_ready;
            sv_sign = 32'(out_sign); sv_scale = 32'(out_scale); sv_mant = 32'(out_mant);
            sv_zero = 32'(out_zero); sv_inf = 32'(out_inf);
            if (in_fire) sent++;
            cyc++;
        end
        chk("stream_received", 32'(rcv),  32'd8);
        chk("stream_sent",     32'(sent), 32'd8);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("stream_no_extra", 32'(out_valid), 32'd0);

        // Reset with two items in flight.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = w[2];
        @(posedge clk); #1;
        in_data = w[3];
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        #1 chk("flush_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("flush_valid_0", 32'(out_valid), 32'd0);
        chk("flush_scale_0", 32'(out_scale), 32'd0);
        @(posedge clk); #2;
        chk("flush_valid_1", 32'(out_valid), 32'd0);
        in_data = w[7]; in_valid = 1'b1;
        #1 chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        #1 chk("flush_lat1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #2;
        chk("flush_lat2_valid", 32'(out_valid), 32'd1);
        chk_fields("flush_next", 7);
        @(posedge clk); #2;
        chk("flush_tail_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
